cache_ctrl_param: RTL and testbench
===================================

Name: cache_ctrl_param

Overview:
Parametrised successor to the single-word cache control FSM. It handles direct-mapped, write-through cache transactions and adds three things: a configurable memory wait-state count, multi-word line refill, and an optional write-allocate mode. It sits between the CPU strobe/handshake and the cache array/memory datapath, and drives the array write enable and the datapath selects.

Parameters:
WAIT_CYCLES, 4, memory access latency in cycles per word; legal range 1..255.
LINE_WORDS, 4, words per cache line refilled on a miss; power of two, 1..16.
WRITE_ALLOC, 0, 0 = write miss bypasses the cache; 1 = write miss refills the line, then writes it.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
Strobe  in  1  CPU request valid; sampled only in IDLE
DRW  in  1  CPU request type: 1 = write, 0 = read; sampled with Strobe
M  in  1  tag match for the current address
V  in  1  valid bit for the current line
DReady  out  1  CPU transaction complete; single-cycle pulse
W  out  1  cache array write enable (data, tag and valid)
MStrobe  out  1  memory request pulse
MRW  out  1  memory direction: 1 = write, 0 = read
RSel  out  1  memory address source: 0 = CPU address, 1 = line base + WordIdx
WSel  out  1  cache write-data source: 0 = CPU data, 1 = memory data
WordIdx  out  $clog2(LINE_WORDS) max 1  refill word index
Busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state goes to IDLE. WordIdx, counter and the pend_wr flag clear to 0. Every output is 0.
- Outputs are Moore (decoded from state). The one exception is DReady in RD_LOOKUP, which equals M&V.
- IDLE:
  - Strobe=1 and DRW=0 -> RD_LOOKUP.
  - Strobe=1 and DRW=1 -> WR_LOOKUP.
  - Strobe is ignored in every other state; there is no queuing.
- RD_LOOKUP:
  - Hit (M&V): DReady=1, go to IDLE.
  - Miss: clear WordIdx and pend_wr, go to FILL_REQ.
- FILL_REQ: MStrobe=1, MRW=0, RSel=1. Load counter with WAIT_CYCLES. Go to FILL_WAIT.
- FILL_WAIT: MRW=0, RSel=1. Counter decrements each cycle. State lasts exactly WAIT_CYCLES cycles, then goes to FILL_WR.
- FILL_WR: W=1, WSel=1, RSel=1.
  - If WordIdx == LINE_WORDS-1: go to WR_HIT when pend_wr=1, else RD_DONE.
  - Otherwise: WordIdx+1, go to FILL_REQ.
- RD_DONE: DReady=1, go to IDLE.
- WR_LOOKUP:
  - Hit: go to WR_HIT.
  - Miss with WRITE_ALLOC=1: set pend_wr, clear WordIdx, go to FILL_REQ.
  - Miss with WRITE_ALLOC=0: go to WR_MEM_REQ. The cache is left untouched.
- WR_HIT: W=1, WSel=0, RSel=0. Clear pend_wr. Go to WR_MEM_REQ.
- WR_MEM_REQ: MStrobe=1, MRW=1, RSel=0. Load counter. Go to WR_MEM_WAIT.
- WR_MEM_WAIT: MRW=1. Lasts WAIT_CYCLES cycles, then goes to WR_DONE.
- WR_DONE: DReady=1, MRW=1. Go to IDLE.
- Latency, with Strobe sampled in cycle 0:
  - Read hit: DReady in cycle 1.
  - Read miss: DReady in cycle 2 + LINE_WORDS*(WAIT_CYCLES+2).
  - Write hit: DReady in cycle WAIT_CYCLES+4.
  - Write miss, no-allocate: DReady in cycle WAIT_CYCLES+3.
  - Write miss, allocate: DReady in cycle LINE_WORDS*(WAIT_CYCLES+2)+WAIT_CYCLES+4.
- The cycle after any DReady is IDLE, so a new Strobe is accepted there (back-to-back operation).
- WordIdx wraps never; it is held between fills. The counter never underflows.
- Reset mid-operation aborts immediately. No memory strobe is emitted after reset release until a new Strobe arrives.
- Illegal or unused state encodings go to IDLE with all outputs 0.

Decomposition:
- Shared package cache_ctrl_pkg holds:
  - the state enum: IDLE, RD_LOOKUP, FILL_REQ, FILL_WAIT, FILL_WR, RD_DONE, WR_LOOKUP, WR_HIT, WR_MEM_REQ, WR_MEM_WAIT, WR_DONE;
  - the counter width constant CTR_W = 8.
- Sub-module cache_wait_ctr: a loadable down-counter with inputs load, load value and enable, and output zero_next (asserted on the final wait cycle).

Test Plan (WAIT_CYCLES=4, LINE_WORDS=4 unless stated; Strobe in cycle 0):
- Read hit, M=V=1 -> DReady=1 in cycle 1 only. W, MStrobe and Busy are 0 from cycle 2 on. A second Strobe in cycle 2 is accepted.
- Read miss, V=0 -> MStrobe (MRW=0, RSel=1) in cycles 2, 8, 14, 20. W with WSel=1 in cycles 7, 13, 19, 25 at WordIdx 0, 1, 2, 3. DReady in cycle 26.
- Write hit -> W with WSel=0 in cycle 2; MStrobe with MRW=1 in cycle 3; DReady in cycle 8.
- Write miss, WRITE_ALLOC=0 -> W never asserts; MStrobe with MRW=1 in cycle 2; DReady in cycle 7.
- Write miss, WRITE_ALLOC=1 -> refill as in the read-miss case (cycles 2-25), CPU write W in cycle 26, MStrobe in cycle 27, DReady in cycle 32.
- Reset asserted in cycle 10 of a read miss -> all outputs 0 and WordIdx=0 immediately. After release, no MStrobe occurs. A Strobe issued after release behaves exactly like a fresh transaction.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the parametrised cache control FSM.
//   state_t     : controller state encoding
//   ctrl_out_t  : bundle of Moore outputs decoded from a state
//   CTR_W       : width of the memory wait-state counter
//   decode()    : state -> Moore output bundle (illegal codes -> all 0)
package cache_ctrl_pkg;

  localparam int CTR_W = 8;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    RD_LOOKUP   = 4'd1,
    FILL_REQ    = 4'd2,
    FILL_WAIT   = 4'd3,
    FILL_WR     = 4'd4,
    RD_DONE     = 4'd5,
    WR_LOOKUP   = 4'd6,
    WR_HIT      = 4'd7,
    WR_MEM_REQ  = 4'd8,
    WR_MEM_WAIT = 4'd9,
    WR_DONE     = 4'd10
  } state_t;

  typedef struct packed {
    logic dready;
    logic w;
    logic mstrobe;
    logic mrw;
    logic rsel;
    logic wsel;
    logic busy;
  } ctrl_out_t;

  function automatic ctrl_out_t decode(state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      IDLE:        ;
      RD_LOOKUP:   o.busy = 1'b1;
      FILL_REQ:    begin o.busy = 1'b1; o.mstrobe = 1'b1; o.rsel = 1'b1; end
      FILL_WAIT:   begin o.busy = 1'b1; o.rsel = 1'b1; end
      FILL_WR:     begin o.busy = 1'b1; o.w = 1'b1; o.wsel = 1'b1; o.rsel = 1'b1; end
      RD_DONE:     begin o.busy = 1'b1; o.dready = 1'b1; end
      WR_LOOKUP:   o.busy = 1'b1;
      WR_HIT:      begin o.busy = 1'b1; o.w = 1'b1; end
      WR_MEM_REQ:  begin o.busy = 1'b1; o.mstrobe = 1'b1; o.mrw = 1'b1; end
      WR_MEM_WAIT: begin o.busy = 1'b1; o.mrw = 1'b1; end
      WR_DONE:     begin o.busy = 1'b1; o.dready = 1'b1; o.mrw = 1'b1; end
      default:     o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cache_ctrl_param_wait_ctr.sv
// Loadable down-counter timing memory wait states.
//   clk, reset : clock, async active-high reset
//   load       : load load_val (takes priority over en)
//   load_val   : wait-state count
//   en         : decrement (never below zero)
//   zero_next  : high during the final enabled wait cycle
module cache_wait_ctr
  import cache_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             en,
  output logic             zero_next
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (load)                   cnt <= load_val;
    else if (en && (cnt != '0))      cnt <= cnt - 1'b1;
  end

  // Loaded with N at the end of the request cycle, so the Nth wait cycle
  // is the one that sees a count of 1.
  assign zero_next = en && (cnt == CTR_W'(1));

endmodule

// File: rtl/cache_ctrl_param.sv
// Direct-mapped, write-through cache control FSM with configurable memory
// wait states, multi-word line refill and optional write-allocate.
//   clk, reset : clock, async active-high reset
//   Strobe/DRW : CPU request valid / type (1 = write), sampled in IDLE
//   M, V       : tag match / line valid for the current address
//   DReady     : transaction complete pulse
//   W          : cache array write enable
//   MStrobe/MRW: memory request pulse / direction (1 = write)
//   RSel, WSel : memory address source / cache write-data source
//   WordIdx    : refill word index
//   Busy       : controller not idle
module cache_ctrl_param
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int LINE_WORDS  = 4,
  parameter int WRITE_ALLOC = 0,
  localparam int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Strobe,
  input  logic             DRW,
  input  logic             M,
  input  logic             V,
  output logic             DReady,
  output logic             W,
  output logic             MStrobe,
  output logic             MRW,
  output logic             RSel,
  output logic             WSel,
  output logic [IDX_W-1:0] WordIdx,
  output logic             Busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [CTR_W-1:0] WAIT_VAL = CTR_W'(WAIT_CYCLES);

  state_t           state, nxt;
  ctrl_out_t        outs;
  logic [IDX_W-1:0] word_idx;
  logic             pend_wr;   // write miss being allocated: finish with a CPU write
  logic             hit;
  logic             ctr_load, ctr_en, ctr_last;

  assign hit = M & V;

  assign ctr_load = (state == FILL_REQ)  || (state == WR_MEM_REQ);
  assign ctr_en   = (state == FILL_WAIT) || (state == WR_MEM_WAIT);

  cache_wait_ctr u_wait_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .load_val  (WAIT_VAL),
    .en        (ctr_en),
    .zero_next (ctr_last)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:        if (Strobe) nxt = DRW ? WR_LOOKUP : RD_LOOKUP;
      RD_LOOKUP:   nxt = hit ? IDLE : FILL_REQ;
      FILL_REQ:    nxt = FILL_WAIT;
      FILL_WAIT:   if (ctr_last) nxt = FILL_WR;
      FILL_WR:     if (word_idx == LAST_IDX) nxt = pend_wr ? WR_HIT : RD_DONE;
                   else                      nxt = FILL_REQ;
      RD_DONE:     nxt = IDLE;
      WR_LOOKUP:   if (hit)                   nxt = WR_HIT;
                   else if (WRITE_ALLOC != 0) nxt = FILL_REQ;
                   else                       nxt = WR_MEM_REQ;
      WR_HIT:      nxt = WR_MEM_REQ;
      WR_MEM_REQ:  nxt = WR_MEM_WAIT;
      WR_MEM_WAIT: if (ctr_last) nxt = WR_DONE;
      WR_DONE:     nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe, without a decode path after the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      outs     <= '0;
      word_idx <= '0;
      pend_wr  <= 1'b0;
    end else begin
      state <= nxt;
      outs  <= decode(nxt);
      case (state)
        RD_LOOKUP:
          if (!hit) begin
            word_idx <= '0;
            pend_wr  <= 1'b0;
          end
        WR_LOOKUP:
          if (!hit && (WRITE_ALLOC != 0)) begin
            word_idx <= '0;
            pend_wr  <= 1'b1;
          end
        FILL_WR:
          if (word_idx != LAST_IDX) word_idx <= word_idx + 1'b1;
        WR_HIT:
          pend_wr <= 1'b0;
        default: ;
      endcase
    end
  end

  // Read hit completes in the lookup cycle itself, so DReady carries the
  // live M&V there in addition to the registered done-state pulse.
  assign DReady  = outs.dready | ((state == RD_LOOKUP) & hit);
  assign W       = outs.w;
  assign MStrobe = outs.mstrobe;
  assign MRW     = outs.mrw;
  assign RSel    = outs.rsel;
  assign WSel    = outs.wsel;
  assign Busy    = outs.busy;
  assign WordIdx = word_idx;

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Self-checking bench for cache_ctrl_param (WAIT_CYCLES=4, LINE_WORDS=4).
// Two instances: dut0 without write-allocate, dut1 with write-allocate.
module tb_cache_ctrl_param;

  localparam int WC = 4;
  localparam int LW = 4;
  localparam int P  = WC + 2;   // cycles per refilled word
  localparam int IW = 2;

  localparam int RH = 0, RM = 1, WH = 2, WMN = 3, WMA = 4;

  logic clk = 1'b0;
  logic reset;
  logic strobe0, strobe1, drw, m, v;
  logic dr0, w0, ms0, mrw0, rs0, ws0, b0;
  logic dr1, w1, ms1, mrw1, rs1, ws1, b1;
  logic [IW-1:0] wi0, wi1;

  always #5 clk = ~clk;

  cache_ctrl_param #(.WAIT_CYCLES(WC), .LINE_WORDS(LW), .WRITE_ALLOC(0)) dut0 (
    .clk(clk), .reset(reset), .Strobe(strobe0), .DRW(drw), .M(m), .V(v),
    .DReady(dr0), .W(w0), .MStrobe(ms0), .MRW(mrw0), .RSel(rs0), .WSel(ws0),
    .WordIdx(wi0), .Busy(b0));

  cache_ctrl_param #(.WAIT_CYCLES(WC), .LINE_WORDS(LW), .WRITE_ALLOC(1)) dut1 (
    .clk(clk), .reset(reset), .Strobe(strobe1), .DRW(drw), .M(m), .V(v),
    .DReady(dr1), .W(w1), .MStrobe(ms1), .MRW(mrw1), .RSel(rs1), .WSel(ws1),
    .WordIdx(wi1), .Busy(b1));

  typedef struct {
    string         nm;
    int            c;
    logic          sel;
    logic          dr, w, ms, busy;
    logic          chk_m, mrw;
    logic          chk_r, rsel;
    logic          chk_w, wsel;
    logic          chk_i;
    logic [IW-1:0] idx;
  } exp_t;

  typedef struct {
    string nm;
    int    kind;
    logic  sel;
    logic  dm, dv;
    bit    hold;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int done_cyc(int k);
    case (k)
      RH:      return 1;
      RM:      return 2 + LW * P;
      WH:      return WC + 4;
      WMN:     return WC + 3;
      default: return LW * P + WC + 4;
    endcase
  endfunction

  // Expected outputs for cycle c of a transaction, from the documented
  // event schedule of each transaction type.
  function automatic exp_t mk(string nm, int k, logic sel, int c);
    exp_t e;
    int d;
    d = done_cyc(k);
    e = '{nm: nm, c: c, sel: sel, dr: (c == d), w: 1'b0, ms: 1'b0, busy: (c >= 1),
          chk_m: 1'b0, mrw: 1'b0, chk_r: 1'b0, rsel: 1'b0, chk_w: 1'b0, wsel: 1'b0,
          chk_i: 1'b0, idx: '0};
    if ((k == RM || k == WMA) && c >= 2 && c < 2 + LW * P) begin
      if ((c - 2) % P == 0) begin
        e.ms = 1'b1; e.chk_m = 1'b1; e.mrw = 1'b0; e.chk_r = 1'b1; e.rsel = 1'b1;
      end
      if ((c - 2) % P == P - 1) begin
        e.w = 1'b1; e.chk_w = 1'b1; e.wsel = 1'b1; e.chk_r = 1'b1; e.rsel = 1'b1;
        e.chk_i = 1'b1; e.idx = IW'((c - 2) / P);
      end
    end
    if (k == WH || k == WMN || k == WMA) begin
      if (c == d - WC - 1) begin
        e.ms = 1'b1; e.chk_m = 1'b1; e.mrw = 1'b1; e.chk_r = 1'b1; e.rsel = 1'b0;
      end
      if (k != WMN && c == d - WC - 2) begin
        e.w = 1'b1; e.chk_w = 1'b1; e.wsel = 1'b0; e.chk_r = 1'b1; e.rsel = 1'b0;
      end
    end
    return e;
  endfunction

  // Scoreboard consumer: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic adr, aw, ams, amrw, ars, aws, ab;
    logic [IW-1:0] awi;
    logic ok;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      adr  = e.sel ? dr1  : dr0;
      aw   = e.sel ? w1   : w0;
      ams  = e.sel ? ms1  : ms0;
      amrw = e.sel ? mrw1 : mrw0;
      ars  = e.sel ? rs1  : rs0;
      aws  = e.sel ? ws1  : ws0;
      ab   = e.sel ? b1   : b0;
      awi  = e.sel ? wi1  : wi0;
      ok = (adr == e.dr) && (aw == e.w) && (ams == e.ms) && (ab == e.busy) &&
           (!e.chk_m || amrw == e.mrw) && (!e.chk_r || ars == e.rsel) &&
           (!e.chk_w || aws == e.wsel) && (!e.chk_i || awi == e.idx);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc%0d: got dr=%b w=%b ms=%b busy=%b mrw=%b rsel=%b wsel=%b idx=%0d want dr=%b w=%b ms=%b busy=%b mrw=%b rsel=%b wsel=%b idx=%0d",
                 e.nm, e.c, adr, aw, ams, ab, amrw, ars, aws, awi,
                 e.dr, e.w, e.ms, e.busy, e.mrw, e.rsel, e.wsel, e.idx);
      end
    end
  end

  // Called just after a rising edge; Strobe is driven in cycle 0 and the
  // task returns just after the edge that starts cycle done+1.
  task automatic run_txn(input vec_t t);
    int d;
    d   = done_cyc(t.kind);
    drw = (t.kind >= WH);
    m   = t.dm;
    v   = t.dv;
    for (int c = 0; c <= d; c++) exp_q.push_back(mk(t.nm, t.kind, t.sel, c));
    if (t.sel) strobe1 = 1'b1; else strobe0 = 1'b1;
    for (int c = 0; c <= d; c++) begin
      @(posedge clk); #1;
      if (!t.hold || c == d) begin strobe0 = 1'b0; strobe1 = 1'b0; end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d pending want 0", t.nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    bit   saw_ms;

    vecs[0]  = '{"rd_hit",          RH,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"rd_hit_b2b",      RH,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"rd_miss_v0",      RM,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"rd_miss_m0",      RM,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"wr_hit",          WH,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"wr_miss_noalloc", WMN, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"wr_miss_v0",      WMN, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"wr_miss_alloc",   WMA, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"wr_hit_alloc",    WH,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"rd_hit_alloc",    RH,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"rd_miss_held",    RM,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"wr_hit_held",     WH,  1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; strobe0 = 1'b0; strobe1 = 1'b0; drw = 1'b0; m = 1'b0; v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", {dr0, w0, ms0, mrw0, rs0, ws0, b0, wi0}, '0);
    chk("reset_outs1", {dr1, w1, ms1, mrw1, rs1, ws1, b1, wi1}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in cycle 10 of a read miss (second word's wait phase).
    drw = 1'b0; m = 1'b0; v = 1'b0; strobe0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      strobe0 = 1'b0;
    end
    chk("midfill_idx", {30'd0, wi0}, 32'd1);
    chk("midfill_busy", {31'd0, b0}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_outs", {dr0, w0, ms0, mrw0, rs0, ws0, b0, wi0}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    saw_ms = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ms0 || b0) saw_ms = 1'b1;
    end
    chk("no_mstrobe_after_reset", {31'd0, saw_ms}, 32'd0);
    @(posedge clk); #1;
    run_txn('{"rd_miss_after_reset", RM, 1'b0, 1'b0, 1'b0, 1'b0});
    run_txn('{"wr_miss_alloc_again", WMA, 1'b1, 1'b1, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
